// File: rtl/ntt_pkg.sv
// ntt_pkg: transform geometry, core latencies and controller state encoding
package ntt_pkg;
  localparam int LOG_N = 10;
  localparam int N = 1 << LOG_N;
  localparam int HALF = N / 2;
  localparam int ADDR_W = LOG_N - 1;
  localparam int DATA_W = 30;
  localparam int CORE_LAT = 6;
  localparam int READ_LAT = 2;
  localparam int GAP_W = $clog2(CORE_LAT);
  localparam int RD_W = $clog2(READ_LAT + 1);
  typedef enum logic [3:0] {
    IDLE, LOAD, RUN, GAP, UNLOAD_RD, UNLOAD_WAIT, UNLOAD_HI, UNLOAD_LO, FINISH
  } state_t;
endpackage

// File: rtl/ntt_stage_counter.sv
// ntt_stage_counter: butterfly index, stage index and inter-stage drain counters
module ntt_stage_counter
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              issue,
  input  logic              gap_en,
  output logic [ADDR_W-1:0] i,
  output logic [3:0]        stage,
  output logic              i_last,
  output logic              stage_last,
  output logic              gap_last
);
  logic [GAP_W-1:0] gap;
  assign i_last = i == ADDR_W'(HALF - 1);
  assign stage_last = stage == 4'(LOG_N - 1);
  assign gap_last = gap == GAP_W'(CORE_LAT - 1);
  // i holds at its terminal value through the drain gap; it restarts with the next stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i <= '0;
      stage <= '0;
      gap <= '0;
    end else if (clr) begin
      i <= '0;
      stage <= '0;
      gap <= '0;
    end else begin
      if (issue && !i_last) i <= i + 1'b1;
      if (gap_en) begin
        gap <= gap_last ? '0 : gap + 1'b1;
        if (gap_last && !stage_last) begin
          stage <= stage + 1'b1;
          i <= '0;
        end
      end
    end
endmodule

// File: rtl/ntt_controller.sv
// ntt_controller: sequences ntt_core through load, all butterfly stages and unload
module ntt_controller
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_in,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        core_log_m,
  output logic [ADDR_W-1:0] core_i,
  output logic [ADDR_W-1:0] core_read_address,
  output logic              core_write_enable,
  output logic              core_mode,
  output logic [ADDR_W-1:0] core_upper_write_address,
  output logic [ADDR_W-1:0] core_lower_write_address,
  output logic [DATA_W-1:0] core_upper_data_input,
  output logic [DATA_W-1:0] core_lower_data_input,
  input  logic [DATA_W-1:0] core_r_upper,
  input  logic [DATA_W-1:0] core_r_lower
);
  state_t state, state_n;
  logic [LOG_N-1:0] k;
  logic [ADDR_W-1:0] j;
  logic [RD_W-1:0] w;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic go, in_fire, j_last, rd_cap, clr, i_last, stage_last, gap_last;
  assign go = state == IDLE && start;
  assign in_fire = state == LOAD && in_valid;
  assign j_last = j == ADDR_W'(HALF - 1);
  assign rd_cap = state == UNLOAD_WAIT && w == RD_W'(READ_LAT - 1);
  assign clr = go || (state == GAP && gap_last && stage_last);
  assign core_read_address = j;
  ntt_stage_counter u_cnt (
    .clk, .rst_n, .clr,
    .issue(state == RUN), .gap_en(state == GAP),
    .i(core_i), .stage(core_log_m),
    .i_last, .stage_last, .gap_last
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    done = state == FINISH;
    in_ready = state == LOAD;
    out_valid = state == UNLOAD_HI || state == UNLOAD_LO;
    out_data = state == UNLOAD_LO ? lo_q : hi_q;
    case (state)
      IDLE:        state_n = start ? LOAD : IDLE;
      LOAD:        state_n = in_valid && &k ? RUN : LOAD;
      RUN:         state_n = i_last ? GAP : RUN;
      GAP:         state_n = !gap_last ? GAP : stage_last ? UNLOAD_RD : RUN;
      UNLOAD_RD:   state_n = UNLOAD_WAIT;
      UNLOAD_WAIT: state_n = rd_cap ? UNLOAD_HI : UNLOAD_WAIT;
      UNLOAD_HI:   state_n = out_ready ? UNLOAD_LO : UNLOAD_HI;
      UNLOAD_LO:   state_n = !out_ready ? UNLOAD_LO : j_last ? FINISH : UNLOAD_RD;
      FINISH:      state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end
  // load writes land one cycle after the handshake; the idle bank keeps its last address/data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      core_write_enable <= 1'b0;
      core_mode <= 1'b0;
      core_upper_write_address <= '0;
      core_lower_write_address <= '0;
      core_upper_data_input <= '0;
      core_lower_data_input <= '0;
      k <= '0;
      j <= '0;
      w <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      core_write_enable <= in_fire;
      if (go) begin
        core_mode <= mode_in;
        k <= '0;
        j <= '0;
      end
      if (in_fire) begin
        k <= k + 1'b1;
        if (k[LOG_N-1]) begin
          core_lower_write_address <= k[ADDR_W-1:0];
          core_lower_data_input <= in_data;
        end else begin
          core_upper_write_address <= k[ADDR_W-1:0];
          core_upper_data_input <= in_data;
        end
      end
      w <= state == UNLOAD_WAIT ? w + 1'b1 : '0;
      if (rd_cap) begin
        hi_q <= core_r_upper;
        lo_q <= core_r_lower;
      end
      if (state == UNLOAD_LO && out_ready) j <= j_last ? '0 : j + 1'b1;
    end
endmodule

// File: tb/tb_ntt_controller.sv
// tb_ntt_controller: randomized scoreboard bench with a memory model of ntt_core
module tb_ntt_controller;
  import ntt_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode_in = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic busy, done, in_ready, out_valid, core_write_enable, core_mode;
  logic [DATA_W-1:0] out_data, core_upper_data_input, core_lower_data_input, core_r_upper, core_r_lower;
  logic [3:0] core_log_m;
  logic [ADDR_W-1:0] core_i, core_read_address, core_upper_write_address, core_lower_write_address;
  int vectors = 0, miscompares = 0;
  typedef struct {
    bit up;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t wq[$];
  logic [DATA_W-1:0] oq[$];
  logic [DATA_W-1:0] ub[HALF], lb[HALF];
  logic [ADDR_W-1:0] p0 = '0, p1 = '0;

  ntt_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_log_m(core_log_m), .core_i(core_i), .core_read_address(core_read_address),
    .core_write_enable(core_write_enable), .core_mode(core_mode),
    .core_upper_write_address(core_upper_write_address), .core_lower_write_address(core_lower_write_address),
    .core_upper_data_input(core_upper_data_input), .core_lower_data_input(core_lower_data_input),
    .core_r_upper(core_r_upper), .core_r_lower(core_r_lower)
  );

  always #5 clk = ~clk;

  // core model: two banks written together on the strobe, reads delayed READ_LAT cycles
  always @(posedge clk) begin
    p0 <= core_read_address;
    p1 <= p0;
    if (core_write_enable) begin
      ub[core_upper_write_address] <= core_upper_data_input;
      lb[core_lower_write_address] <= core_lower_data_input;
    end
  end
  assign core_r_upper = ub[p1];
  assign core_r_lower = lb[p1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin : wr_mon
    wr_t e;
    @(negedge clk);
    #2;
    if (rst_n && core_write_enable) begin
      chk("wr_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk(e.up ? "wr_upper" : "wr_lower",
            e.up ? {core_upper_write_address, core_upper_data_input} : {core_lower_write_address, core_lower_data_input},
            {e.a, e.d});
      end
    end
  end

  always begin : out_mon
    logic hold;
    logic [DATA_W-1:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) chk("out_stable", {out_valid, out_data}, {1'b1, held});
        if (out_valid && out_ready) begin
          chk("out_expected", 64'(oq.size() != 0), 64'd1);
          if (oq.size() != 0) chk("out_data", out_data, oq.pop_front());
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end
    end
  end

  task automatic run_xfer(input bit m, input bit hold_start, input int nwords);
    logic [DATA_W-1:0] d[N];
    int k, cyc;
    bit v;
    for (int x = 0; x < N; x++) d[x] = DATA_W'($urandom);
    mode_in = m;
    start = 1'b1;
    k = 0;
    cyc = 0;
    while (k < nwords && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("start_accept", {busy, in_ready}, 2'b11);
      if (!hold_start) start = 1'b0;
      mode_in = 1'($urandom);
      v = $urandom_range(0, 3) != 0;
      in_valid = v;
      in_data = d[k];
      if (v && in_ready) begin
        wq.push_back('{k < HALF, ADDR_W'(k % HALF), d[k]});
        k++;
      end
    end
    chk("load_count", 64'(k), 64'(nwords));
    if (nwords < N) return;
    for (int x = 0; x < HALF; x++) begin
      oq.push_back(d[x]);
      oq.push_back(d[x + HALF]);
    end
    for (int s = 0; s < LOG_N; s++)
      for (int x = 0; x < HALF + CORE_LAT; x++) begin
        @(negedge clk);
        in_valid = 1'($urandom);
        if (s == 3 && x == 100) start = 1'b1;
        else if (!hold_start) start = 1'b0;
        chk("run_trace", {core_log_m, core_i, core_mode, out_valid, in_ready, busy},
            {4'(s), ADDR_W'(x < HALF ? x : HALF - 1), m, 1'b0, 1'b0, 1'b1});
      end
    if (!hold_start) start = 1'b0;
    cyc = 0;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      out_ready = 1'($urandom);
      in_valid = 1'($urandom);
    end
    chk("done_seen", {done, busy}, 2'b11);
    chk("oq_drained", 64'(oq.size()), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("done_pulse", {done, busy}, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, in_ready, out_valid, core_write_enable, core_mode, core_log_m, core_i, core_read_address}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(1'b1, 1'b0, 100);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midload_rst_ctrl", {busy, done, in_ready, out_valid, core_write_enable, core_mode, core_log_m, core_i,
        core_read_address, core_upper_write_address, core_lower_write_address}, '0);
    chk("midload_rst_data", {core_upper_data_input, core_lower_data_input}, '0);
    wq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(1'b0, 1'b0, N);
    run_xfer(1'b1, 1'b1, N);
    run_xfer(1'b0, 1'b1, N);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", {busy, done, in_ready, out_valid}, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
